// File: rtl/reset_seq_ctrl_if.sv
// Reset-sequencer signal bundle: strap/software requests in, ordered resets out.
// The sequencer uses the slave view; the strap/pad side uses the master view.
interface reset_seq_ctrl_if;
  logic       soft_reboot_req;
  logic       strap_cpu_rst_rel;
  logic       cpu_rel;
  logic       p_reset_n;
  logic       clk_enb;
  logic       s_reset_n;
  logic       cpu_reset_n;
  logic       boot_done;
  logic [2:0] seq_state;

  modport slave (
    input  soft_reboot_req, strap_cpu_rst_rel, cpu_rel,
    output p_reset_n, clk_enb, s_reset_n, cpu_reset_n, boot_done, seq_state
  );

  modport master (
    output soft_reboot_req, strap_cpu_rst_rel, cpu_rel,
    input  p_reset_n, clk_enb, s_reset_n, cpu_reset_n, boot_done, seq_state
  );
endinterface

// File: rtl/reset_seq_ctrl.sv
// Reset-removal sequencer: POR -> clock enable -> soft reset -> core release,
// plus soft reboot that re-pulses s_reset_n while p_reset_n stays high.
module reset_seq_ctrl #(
  parameter int CNT_W      = 8,
  parameter int P_RST_CYC  = 16,
  parameter int CLK_EN_CYC = 8,
  parameter int S_RST_CYC  = 8
) (
  input  logic             clk,
  input  logic             reset,
  reset_seq_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    POR    = 3'd0,
    CLKW   = 3'd1,
    SRSTW  = 3'd2,
    RUN    = 3'd3,
    REBOOT = 3'd4,
    RBWAIT = 3'd5
  } state_t;

  localparam longint CNT_MAX = (64'd1 << CNT_W) - 64'd1;

  if (P_RST_CYC < 1 || longint'(P_RST_CYC) > CNT_MAX ||
      CLK_EN_CYC < 1 || longint'(CLK_EN_CYC) > CNT_MAX ||
      S_RST_CYC < 1 || longint'(S_RST_CYC) > CNT_MAX) begin : g_bad_delay
    $error("reset_seq_ctrl: delay parameter outside 1..2^CNT_W-1");
  end

  localparam logic [CNT_W-1:0] P_TC  = CNT_W'(P_RST_CYC - 1);
  localparam logic [CNT_W-1:0] CE_TC = CNT_W'(CLK_EN_CYC - 1);
  localparam logic [CNT_W-1:0] S_TC  = CNT_W'(S_RST_CYC - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             req_p0, req_p1, req_p2;
  logic             auto_rel;
  logic             p_reset_n_q, clk_enb_q, s_reset_n_q, cpu_reset_n_q, boot_done_q;
  logic             trig;

  // Request synchroniser: p0/p1 resolve metastability, p2 gives edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_p0 <= 1'b0;
      req_p1 <= 1'b0;
      req_p2 <= 1'b0;
    end else begin
      req_p0 <= bus.soft_reboot_req;
      req_p1 <= req_p0;
      req_p2 <= req_p1;
    end
  end

  assign trig = req_p1 & ~req_p2;

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= POR;
      cnt           <= '0;
      auto_rel      <= 1'b0;
      p_reset_n_q   <= 1'b0;
      clk_enb_q     <= 1'b0;
      s_reset_n_q   <= 1'b0;
      cpu_reset_n_q <= 1'b0;
      boot_done_q   <= 1'b0;
    end else begin
      boot_done_q <= 1'b0;
      case (state)
        POR: begin
          if (cnt == P_TC) begin
            cnt         <= '0;
            p_reset_n_q <= 1'b1;
            state       <= CLKW;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CLKW: begin
          if (cnt == CE_TC) begin
            cnt       <= '0;
            clk_enb_q <= 1'b1;
            state     <= SRSTW;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SRSTW: begin
          if (cnt == S_TC) begin
            cnt         <= '0;
            s_reset_n_q <= 1'b1;
            boot_done_q <= 1'b1;
            auto_rel    <= bus.strap_cpu_rst_rel;
            state       <= RUN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          // Reboot takes priority over a coincident core release
          if (trig) begin
            cnt           <= '0;
            s_reset_n_q   <= 1'b0;
            cpu_reset_n_q <= 1'b0;
            state         <= REBOOT;
          end else if (auto_rel || bus.cpu_rel) begin
            cpu_reset_n_q <= 1'b1;
          end
        end
        REBOOT: begin
          if (cnt == S_TC) begin
            cnt   <= '0;
            state <= RBWAIT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RBWAIT: begin
          // Strap control clears the sticky request while s_reset_n is low
          if (!req_p1) begin
            s_reset_n_q <= 1'b1;
            boot_done_q <= 1'b1;
            auto_rel    <= bus.strap_cpu_rst_rel;
            state       <= RUN;
          end
        end
        default: begin
          cnt           <= '0;
          p_reset_n_q   <= 1'b0;
          clk_enb_q     <= 1'b0;
          s_reset_n_q   <= 1'b0;
          cpu_reset_n_q <= 1'b0;
          state         <= POR;
        end
      endcase
    end
  end

  assign bus.p_reset_n   = p_reset_n_q;
  assign bus.clk_enb     = clk_enb_q;
  assign bus.s_reset_n   = s_reset_n_q;
  assign bus.cpu_reset_n = cpu_reset_n_q;
  assign bus.boot_done   = boot_done_q;
  assign bus.seq_state   = state;

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// Scoreboard bench for reset_seq_ctrl: expected output snapshots are queued per
// clk edge (counted from reset release) and compared on the following negedge.
module tb_reset_seq_ctrl;

  localparam logic [2:0] S_POR    = 3'd0;
  localparam logic [2:0] S_CLKW   = 3'd1;
  localparam logic [2:0] S_SRSTW  = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_REBOOT = 3'd4;
  localparam logic [2:0] S_RBWAIT = 3'd5;

  typedef struct {
    int         at;
    string      tag;
    logic [7:0] exp;
  } sb_t;

  logic clk;
  logic reset;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  sb_t  sb_q[$];

  reset_seq_ctrl_if rif();

  reset_seq_ctrl #(
    .CNT_W     (8),
    .P_RST_CYC (16),
    .CLK_EN_CYC(8),
    .S_RST_CYC (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (rif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  function automatic logic [7:0] ov(logic [2:0] st, logic p, logic ce, logic s,
                                    logic cpu, logic bd);
    return {st, p, ce, s, cpu, bd};
  endfunction

  function automatic logic [7:0] obs_vec();
    return {rif.seq_state, rif.p_reset_n, rif.clk_enb, rif.s_reset_n,
            rif.cpu_reset_n, rif.boot_done};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic exp_at(input int at, input string tag, input logic [7:0] v);
    sb_t it;
    it.at  = at;
    it.tag = tag;
    it.exp = v;
    sb_q.push_back(it);
  endtask

  task automatic wait_cyc(input int n);
    int guard;
    guard = 0;
    while (cyc != n && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != n) check_eq("wait_timeout", cyc, n);
  endtask

  // Boot timeline up to and including RUN entry at edge 32
  task automatic push_boot(input string pfx);
    exp_at(15, {pfx, "_por_hold"},   ov(S_POR,   0, 0, 0, 0, 0));
    exp_at(16, {pfx, "_p_rise"},     ov(S_CLKW,  1, 0, 0, 0, 0));
    exp_at(23, {pfx, "_clkw_hold"},  ov(S_CLKW,  1, 0, 0, 0, 0));
    exp_at(24, {pfx, "_ce_rise"},    ov(S_SRSTW, 1, 1, 0, 0, 0));
    exp_at(31, {pfx, "_srstw_hold"}, ov(S_SRSTW, 1, 1, 0, 0, 0));
    exp_at(32, {pfx, "_s_rise_bd"},  ov(S_RUN,   1, 1, 1, 0, 1));
  endtask

  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].at <= cyc) begin
      sb_t it;
      it = sb_q.pop_front();
      if (it.at < cyc) check_eq({it.tag, "_missed"}, cyc, it.at);
      else             check_eq(it.tag, obs_vec(), it.exp);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    rif.soft_reboot_req   = 1'b0;
    rif.strap_cpu_rst_rel = 1'b1;
    rif.cpu_rel           = 1'b0;
    #1 reset = 1'b1;

    // Boot with auto core release
    exp_at(0, "rst_state", ov(S_POR, 0, 0, 0, 0, 0));
    push_boot("a");
    exp_at(33, "a_cpu_auto", ov(S_RUN, 1, 1, 1, 1, 0));
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;

    // Soft reboot, request cleared 4 cycles after s_reset_n falls
    exp_at(42, "b_run_pre",   ov(S_RUN,    1, 1, 1, 1, 0));
    exp_at(43, "b_trig",      ov(S_REBOOT, 1, 1, 0, 0, 0));
    exp_at(47, "b_hold",      ov(S_REBOOT, 1, 1, 0, 0, 0));
    exp_at(50, "b_hold_end",  ov(S_REBOOT, 1, 1, 0, 0, 0));
    exp_at(51, "b_rbwait",    ov(S_RBWAIT, 1, 1, 0, 0, 0));
    exp_at(52, "b_rerun_bd",  ov(S_RUN,    1, 1, 1, 0, 1));
    exp_at(53, "b_cpu_auto",  ov(S_RUN,    1, 1, 1, 1, 0));
    wait_cyc(40);
    rif.soft_reboot_req = 1'b1;
    wait_cyc(47);
    rif.soft_reboot_req = 1'b0;

    // Asynchronous reset while in RUN, then again mid-CLKW
    wait_cyc(55);
    #2 reset = 1'b1;
    #1 check_eq("rst_run_async", obs_vec(), ov(S_POR, 0, 0, 0, 0, 0));
    rif.strap_cpu_rst_rel = 1'b0;
    repeat (3) @(negedge clk);
    exp_at(15, "c_por_hold", ov(S_POR,  0, 0, 0, 0, 0));
    exp_at(16, "c_p_rise",   ov(S_CLKW, 1, 0, 0, 0, 0));
    exp_at(20, "c_clkw",     ov(S_CLKW, 1, 0, 0, 0, 0));
    #2 reset = 1'b0;
    wait_cyc(20);
    #2 reset = 1'b1;
    #1 check_eq("rst_clkw_async", obs_vec(), ov(S_POR, 0, 0, 0, 0, 0));
    @(negedge clk);
    check_eq("rst_clkw_held", obs_vec(), ov(S_POR, 0, 0, 0, 0, 0));

    // Boot without auto release; cpu_rel in SRSTW ignored, in RUN honoured
    push_boot("d");
    exp_at(33, "d_no_auto",   ov(S_RUN, 1, 1, 1, 0, 0));
    exp_at(50, "d_still_rst", ov(S_RUN, 1, 1, 1, 0, 0));
    exp_at(51, "d_cpu_rel",   ov(S_RUN, 1, 1, 1, 1, 0));
    exp_at(52, "d_cpu_held",  ov(S_RUN, 1, 1, 1, 1, 0));
    #2 reset = 1'b0;
    wait_cyc(26);
    rif.cpu_rel = 1'b1;
    wait_cyc(27);
    rif.cpu_rel = 1'b0;
    wait_cyc(50);
    rif.cpu_rel = 1'b1;
    wait_cyc(51);
    rif.cpu_rel = 1'b0;

    // Reboot, re-entry without auto release, then reboot coinciding with cpu_rel
    exp_at(62, "e_run_pre",   ov(S_RUN,    1, 1, 1, 1, 0));
    exp_at(63, "e_trig",      ov(S_REBOOT, 1, 1, 0, 0, 0));
    exp_at(71, "e_rbwait",    ov(S_RBWAIT, 1, 1, 0, 0, 0));
    exp_at(72, "e_rerun_bd",  ov(S_RUN,    1, 1, 1, 0, 1));
    exp_at(73, "e_no_auto",   ov(S_RUN,    1, 1, 1, 0, 0));
    exp_at(82, "e_run_wait",  ov(S_RUN,    1, 1, 1, 0, 0));
    exp_at(83, "e_trig_wins", ov(S_REBOOT, 1, 1, 0, 0, 0));
    exp_at(84, "e_cpu_low",   ov(S_REBOOT, 1, 1, 0, 0, 0));
    wait_cyc(60);
    rif.soft_reboot_req = 1'b1;
    wait_cyc(67);
    rif.soft_reboot_req = 1'b0;
    wait_cyc(80);
    rif.soft_reboot_req = 1'b1;
    wait_cyc(82);
    rif.cpu_rel = 1'b1;
    wait_cyc(83);
    rif.cpu_rel = 1'b0;

    // Reset mid-REBOOT; request left high must not trigger after the new boot
    wait_cyc(86);
    #2 reset = 1'b1;
    #1 check_eq("rst_reboot_async", obs_vec(), ov(S_POR, 0, 0, 0, 0, 0));
    rif.strap_cpu_rst_rel = 1'b1;
    repeat (3) @(negedge clk);
    push_boot("f");
    exp_at(33, "f_cpu_auto",  ov(S_RUN, 1, 1, 1, 1, 0));
    exp_at(45, "f_no_trig",   ov(S_RUN, 1, 1, 1, 1, 0));
    exp_at(60, "f_still_run", ov(S_RUN, 1, 1, 1, 1, 0));
    #2 reset = 1'b0;
    wait_cyc(61);
    rif.soft_reboot_req = 1'b0;

    check_eq("sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reset_seq_ctrl.md
Name: reset_seq_ctrl

Overview:
Reset-removal sequencer for the pinmux/strap domain. It generates the power-on reset (p_reset_n), the clock enable (clk_enb), the soft reset (s_reset_n) and the RISC-V core reset (cpu_reset_n) in a fixed order, with programmable gaps between steps. It also services the soft-reboot request carried in strap_sticky bit[31] by re-pulsing s_reset_n while p_reset_n stays high, so sticky straps survive the reboot. It sits between the external reset pad logic and the strap control, clock-gating and core blocks.

Parameters:
CNT_W, 8, width of the internal delay counter.
P_RST_CYC, 16, clk edges from reset deassertion to p_reset_n rise; legal range 1..2^CNT_W-1.
CLK_EN_CYC, 8, clk edges from p_reset_n rise to clk_enb rise; legal range 1..2^CNT_W-1.
S_RST_CYC, 8, clk edges from clk_enb rise to s_reset_n rise; also the minimum soft-reboot hold. Legal range 1..2^CNT_W-1.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset (synchronised external reset)
soft_reboot_req  input  1  strap_sticky[31]; asynchronous to clk, double-synchronised inside the block
strap_cpu_rst_rel  input  1  strap_sticky[12]; 1 = release the core automatically at boot; sampled in RUN entry
cpu_rel  input  1  single-cycle software pulse that releases the core when auto-release is off
p_reset_n  output  1  power-on reset, active-low
clk_enb  output  1  clock enable for the gated domains
s_reset_n  output  1  soft reset, active-low
cpu_reset_n  output  1  RISC-V reset, active-low
boot_done  output  1  one-cycle pulse on every entry to RUN
seq_state  output  3  current FSM state encoding, for debug

Behaviour:
- Reset is asynchronous, active-high. While reset=1:
  - state=POR, counter=0, sync flops=0.
  - p_reset_n=0, clk_enb=0, s_reset_n=0, cpu_reset_n=0, boot_done=0.
- All outputs are registered; no combinational path from any input to any output.
- The counter clears on every state transition and increments once per clk in each counting state.
- States and encodings: POR=0, CLKW=1, SRSTW=2, RUN=3, REBOOT=4, RBWAIT=5. Encodings 6 and 7 are illegal and go to POR on the next clk.
- POR:
  - Count P_RST_CYC edges.
  - p_reset_n rises at the P_RST_CYC-th rising edge after reset deasserts; go to CLKW.
- CLKW:
  - clk_enb rises CLK_EN_CYC edges after p_reset_n rises; go to SRSTW.
- SRSTW:
  - s_reset_n rises S_RST_CYC edges after clk_enb rises; go to RUN.
  - boot_done pulses in the same cycle that s_reset_n rises.
- RUN, core release:
  - If strap_cpu_rst_rel=1 on the edge that enters RUN, cpu_reset_n rises one edge after s_reset_n.
  - Otherwise cpu_reset_n stays 0 until a cpu_rel pulse is seen in RUN; it rises on the edge after that pulse.
  - cpu_rel outside RUN is ignored.
- RUN, soft reboot:
  - Trigger: rising edge of the synchronised soft_reboot_req (sync2 & ~sync3). Request-to-trigger latency is 3 edges.
  - On the trigger edge: go to REBOOT, s_reset_n=0, cpu_reset_n=0.
  - p_reset_n and clk_enb stay 1.
  - A soft_reboot_req that is already high on RUN entry does not trigger.
- REBOOT: hold S_RST_CYC edges, then go to RBWAIT.
- RBWAIT:
  - Wait for synchronised soft_reboot_req=0. Strap control clears bit[31] while s_reset_n=0.
  - When it reads 0: s_reset_n=1, go to RUN, pulse boot_done.
  - Core release on this RUN entry follows the same rules as at boot.
- Simultaneous events:
  - If a trigger and cpu_rel coincide in RUN, the reboot wins and cpu_reset_n stays 0.
  - A new trigger during REBOOT or RBWAIT is ignored.
- Reset mid-operation: reset=1 in any state returns all outputs to 0 asynchronously and restarts from POR.
- Counter width: a terminal count compares against PARAM-1. Delay parameters must fit CNT_W; values above 2^CNT_W-1 are illegal and trapped by an elaboration assertion.

Test Plan:
1. Defaults, reset released at t0 -> p_reset_n rises at edge 16, clk_enb at 24, s_reset_n at 32, boot_done pulses at 32, seq_state=3 afterwards.
2. strap_cpu_rst_rel=1 -> cpu_reset_n rises at edge 33.
3. strap_cpu_rst_rel=0 -> cpu_reset_n stays 0 for 100 cycles; cpu_rel pulse at edge 50 -> cpu_reset_n=1 at edge 51.
4. In RUN, soft_reboot_req rises, bench clears it 4 cycles after s_reset_n falls:
   - s_reset_n and cpu_reset_n fall 3 edges after the request.
   - s_reset_n stays low at least 8 edges, and until the synchronised request reads 0.
   - p_reset_n and clk_enb stay 1 throughout; boot_done pulses again on the RUN re-entry.
5. Reboot trigger and cpu_rel on the same edge -> REBOOT entered, cpu_reset_n=0.
6. reset asserted mid-CLKW and mid-REBOOT -> all outputs 0 immediately; the full 16/24/32 sequence repeats after release.
